// File: rtl/math_regfile_pkg.sv
// Shared processing types for the math pipeline and its register file.
// Register data is signed fixed-point; the regfile itself never does arithmetic on it.
package math_regfile_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 18;

    typedef logic        [ADDR_W-1:0] reg_addr_t;
    typedef logic signed [DATA_W-1:0] reg_dat_t;

endpackage

// File: rtl/math_regfile.sv
// Flop-based register file serving the math pipeline read/writeback port plus a
// valid/ready memory-side port, with write-first bypass on both read paths.
module math_regfile
    import math_regfile_pkg::*;
#(
    parameter int NUM_REGS = math_regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = math_regfile_pkg::ADDR_W,
    parameter int DATA_W   = math_regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] regfile_read_addr,
    output logic [DATA_W-1:0] stage_2_dat,
    input  logic [ADDR_W-1:0] regfile_write_addr,
    input  logic [DATA_W-1:0] regfile_dat_w,
    input  logic              regfile_we,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_we,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_dat,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_dat
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] stage_2_q, stage_2_d;
    logic [DATA_W-1:0] mem_rsp_dat_q, mem_rsp_dat_d;
    logic              mem_rsp_valid_q, mem_rsp_valid_d;
    logic              mem_accept;
    logic              mem_wr;
    logic              mem_rd;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

    // A math write wins over a memory write; ready keeps them from ever colliding.
    function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!in_range(addr)) begin
            val = '0;
        end else if (regfile_we && regfile_write_addr == addr) begin
            val = regfile_dat_w;
        end else if (mem_wr && mem_req_addr == addr) begin
            val = mem_req_dat;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    assign mem_req_ready = !reset && !(mem_req_we && regfile_we);
    assign mem_accept    = mem_req_valid && mem_req_ready;
    assign mem_wr        = mem_accept && mem_req_we;
    assign mem_rd        = mem_accept && !mem_req_we;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (mem_wr && 32'(mem_req_addr) == i) begin
                regs_d[i] = mem_req_dat;
            end
            if (regfile_we && 32'(regfile_write_addr) == i) begin
                regs_d[i] = regfile_dat_w;
            end
        end
        stage_2_d       = freeze ? stage_2_q : bypass_read(regfile_read_addr);
        mem_rsp_valid_d = mem_rd;
        mem_rsp_dat_d   = mem_rd ? bypass_read(mem_req_addr) : mem_rsp_dat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            stage_2_q       <= '0;
            mem_rsp_valid_q <= 1'b0;
            mem_rsp_dat_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            stage_2_q       <= stage_2_d;
            mem_rsp_valid_q <= mem_rsp_valid_d;
            mem_rsp_dat_q   <= mem_rsp_dat_d;
        end
    end

    assign stage_2_dat   = stage_2_q;
    assign mem_rsp_valid = mem_rsp_valid_q;
    assign mem_rsp_dat   = mem_rsp_dat_q;

endmodule

// File: tb/tb_math_regfile.sv
// Scoreboard bench for math_regfile: a behavioural register model predicts each
// cycle's stage_2_dat and memory responses, which are queued and popped after the edge.
module tb_math_regfile;
    import math_regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              freeze;
    logic [ADDR_W-1:0] regfile_read_addr;
    logic [DATA_W-1:0] stage_2_dat;
    logic [ADDR_W-1:0] regfile_write_addr;
    logic [DATA_W-1:0] regfile_dat_w;
    logic              regfile_we;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_dat;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_dat;

    logic [DATA_W-1:0] model_regs [NUM_REGS];
    logic [DATA_W-1:0] model_s2;
    logic [DATA_W-1:0] model_rsp_dat;
    logic [DATA_W-1:0] s2_q  [$];
    logic [DATA_W-1:0] rsp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    math_regfile dut (
        .clk                (clk),
        .reset              (reset),
        .freeze             (freeze),
        .regfile_read_addr  (regfile_read_addr),
        .stage_2_dat        (stage_2_dat),
        .regfile_write_addr (regfile_write_addr),
        .regfile_dat_w      (regfile_dat_w),
        .regfile_we         (regfile_we),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_dat        (mem_req_dat),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_dat        (mem_rsp_dat)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-first view of the model: math data, then memory write data, then storage.
    function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a,
                                                    input logic we, input logic [ADDR_W-1:0] waddr,
                                                    input logic [DATA_W-1:0] wdat, input logic mwr,
                                                    input logic [ADDR_W-1:0] maddr,
                                                    input logic [DATA_W-1:0] mdat);
        if (we && waddr == a) return wdat;
        if (mwr && maddr == a) return mdat;
        return model_regs[a];
    endfunction

    task automatic applyStimulus(input logic rst, input logic frz, input logic [ADDR_W-1:0] raddr,
                                 input logic we, input logic [ADDR_W-1:0] waddr,
                                 input logic [DATA_W-1:0] wdat, input logic mvalid, input logic mwe,
                                 input logic [ADDR_W-1:0] maddr, input logic [DATA_W-1:0] mdat);
        logic              exp_ready;
        logic              acc;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_s2;
        reset              = rst;
        freeze             = frz;
        regfile_read_addr  = raddr;
        regfile_we         = we;
        regfile_write_addr = waddr;
        regfile_dat_w      = wdat;
        mem_req_valid      = mvalid;
        mem_req_we         = mwe;
        mem_req_addr       = maddr;
        mem_req_dat        = mdat;
        #2;
        exp_ready = !rst && !(mwe && we);
        acc       = mvalid && exp_ready;
        exp_valid = acc && !mwe && !rst;
        checkOutput("mem_req_ready", {31'd0, mem_req_ready}, {31'd0, exp_ready});
        if (rst) exp_s2 = '0;
        else if (frz) exp_s2 = model_s2;
        else exp_s2 = modelRead(raddr, we, waddr, wdat, acc && mwe, maddr, mdat);
        s2_q.push_back(exp_s2);
        if (exp_valid) rsp_q.push_back(modelRead(maddr, we, waddr, wdat, 1'b0, maddr, mdat));
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        end else begin
            if (acc && mwe) model_regs[maddr] = mdat;
            if (we) model_regs[waddr] = wdat;
        end
        model_s2 = exp_s2;
        @(posedge clk);
        #1;
        checkOutput("stage_2_dat", 32'(stage_2_dat), 32'(s2_q.pop_front()));
        checkOutput("mem_rsp_valid", {31'd0, mem_rsp_valid}, {31'd0, exp_valid});
        if (rst) model_rsp_dat = '0;
        else if (exp_valid && rsp_q.size() != 0) model_rsp_dat = rsp_q.pop_front();
        rsp_q.delete();
        checkOutput("mem_rsp_dat", 32'(mem_rsp_dat), 32'(model_rsp_dat));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        model_s2      = '0;
        model_rsp_dat = '0;

        // Reset with a pending memory read that must be ignored, then read each register.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 2, 0);
        for (int a = 0; a < NUM_REGS; a++) begin
            applyStimulus(0, 0, ADDR_W'(a), 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t1_reset_read", 32'(stage_2_dat), 32'd0);
        end

        applyStimulus(0, 0, 0, 1, 2, 18'h00ABC, 0, 0, 0, 0);
        applyStimulus(0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_read_reg2", 32'(stage_2_dat), 32'h00ABC);

        applyStimulus(0, 0, 1, 1, 1, 18'h3FFFF, 0, 0, 0, 0);
        checkOutput("t3_bypass", 32'(stage_2_dat), 32'h3FFFF);

        applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 0, 0, 0, 1, 1, 3, 18'd5);
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_frozen", 32'(stage_2_dat), 32'd0);
        applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_after_freeze", 32'(stage_2_dat), 32'd5);

        applyStimulus(0, 0, 0, 1, 1, 18'h3FFFF, 1, 1, 0, 18'h01234);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 18'h01234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_write_landed", 32'(stage_2_dat), 32'h01234);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("t6_rsp0", 32'(mem_rsp_dat), 32'h01234);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("t6_rsp1", 32'(mem_rsp_dat), 32'h3FFFF);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        checkOutput("t6_rsp2", 32'(mem_rsp_dat), 32'h00ABC);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_no_pulse_after_reset", {31'd0, mem_rsp_valid}, 32'd0);

        // Same-cycle math write and memory read of one address returns the math data.
        applyStimulus(0, 0, 0, 1, 2, 18'h2AAAA, 1, 0, 2, 0);
        checkOutput("sim_write_read", 32'(mem_rsp_dat), 32'h2AAAA);

        for (int n = 0; n < 80; n++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom), ADDR_W'($urandom),
                          1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                          1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
